// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO, runtime parity and stop-bit config.
// Config is captured per frame when the head word is popped.
module uart_tx_fifo #(
    parameter int ClkFrequency = 25000000,
    parameter int Baud         = 115200,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         TxD_start,
    input  logic [DATA_BITS-1:0]         TxD_data,
    input  logic [1:0]                   cfg_parity,
    input  logic                         cfg_stop2,
    output logic                         TxD,
    output logic                         TxD_busy,
    output logic                         fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         tx_overflow
);

    localparam int DIV = ClkFrequency / Baud;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    if (DIV < 2) begin : g_div_chk
        $error("uart_tx_fifo: ClkFrequency/Baud must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_chk
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          count_q;
    logic                 ovf_q;
    logic                 push, pop, full, empty;

    state_e               state_q, state_d;
    logic [DW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 par_en_q, par_en_d;
    logic                 stop2_q, stop2_d;
    logic                 stop_q, stop_d;
    logic                 txd_q, txd_d;
    logic                 bit_end;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign push    = TxD_start & ~full;
    assign pop     = (state_q == S_IDLE) & ~empty;
    assign bit_end = (cnt_q == DIV_LAST);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= TxD_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (AW + 1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (AW + 1)'(1);
            end
            if (TxD_start && full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
            stop_q   <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            par_en_q <= par_en_d;
            stop2_q  <= stop2_d;
            stop_q   <= stop_d;
            txd_q    <= txd_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        par_en_d = par_en_q;
        stop2_d  = stop2_q;
        stop_d   = stop_q;
        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + DW'(1);
        end
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    state_d  = S_START;
                    shift_d  = mem_q[rd_ptr_q];
                    par_en_d = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
                    par_d    = (^mem_q[rd_ptr_q]) ^ cfg_parity[1];
                    stop2_d  = cfg_stop2;
                    stop_d   = 1'b0;
                    bit_d    = '0;
                    cnt_d    = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_q) begin
                        stop_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line level follows the next state so TxD is a clean flop output.
    always_comb begin
        txd_d = 1'b1;
        unique case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
            S_PARITY: txd_d = par_d;
            default:  txd_d = 1'b1;
        endcase
    end

    assign TxD         = txd_q;
    assign TxD_busy    = (state_q != S_IDLE) | ~empty;
    assign fifo_full   = full;
    assign fifo_count  = count_q;
    assign tx_overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at DIV=4, 8 data bits, 4-entry FIFO.
// Each frame is checked sample by sample against hand-derived bit sequences.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst;
    logic       TxD_start;
    logic [7:0] TxD_data;
    logic [1:0] cfg_parity;
    logic       cfg_stop2;
    logic       TxD;
    logic       TxD_busy;
    logic       fifo_full;
    logic [2:0] fifo_count;
    logic       tx_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_fifo #(
        .ClkFrequency(16),
        .Baud        (4),
        .DATA_BITS   (8),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .TxD_start  (TxD_start),
        .TxD_data   (TxD_data),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .TxD        (TxD),
        .TxD_busy   (TxD_busy),
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count),
        .tx_overflow(tx_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        TxD_start = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        TxD_start = 1'b1;
        TxD_data  = d;
        tick();
    endtask

    // Checks every line sample of one frame, skipping samples already elapsed.
    task automatic frame(input logic [7:0] d, input logic pe, input logic pb,
                         input logic s2, input int skip);
        logic [11:0] b;
        int          n;
        b    = '1;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[i+1] = d[i];
        n = 9;
        if (pe) begin
            b[n] = pb;
            n++;
        end
        b[n] = 1'b1;
        n++;
        if (s2) begin
            b[n] = 1'b1;
            n++;
        end
        for (int s = skip; s < n * 4; s++) begin
            tick();
            chk($sformatf("txd_%0h_s%0d", d, s), TxD, b[s/4]);
        end
        chk("busy_in_frame", TxD_busy, 1);
    endtask

    task automatic gap(input logic busy_exp);
        tick();
        chk("gap_txd", TxD, 1);
        chk("gap_busy", TxD_busy, busy_exp);
    endtask

    initial begin
        int lows;
        rst        = 1'b1;
        TxD_start  = 1'b0;
        TxD_data   = '0;
        cfg_parity = 2'b00;
        cfg_stop2  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_txd", TxD, 1);
        chk("rst_busy", TxD_busy, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_full", fifo_full, 0);
        chk("rst_ovf", tx_overflow, 0);
        rst = 1'b0;

        // first edge after release accepts the write
        push(8'hA5);
        chk("first_wr_count", fifo_count, 1);
        chk("first_wr_txd", TxD, 1);
        frame(8'hA5, 0, 0, 0, 0);
        gap(0);

        cfg_parity = 2'b01;
        push(8'hA5);
        frame(8'hA5, 1, 0, 0, 0);
        gap(0);

        cfg_parity = 2'b10;
        cfg_stop2  = 1'b1;
        push(8'hA5);
        frame(8'hA5, 1, 1, 1, 0);
        gap(0);

        // two queued words run back to back
        cfg_parity = 2'b00;
        cfg_stop2  = 1'b0;
        push(8'h00);
        TxD_start = 1'b1;
        TxD_data  = 8'hFF;
        frame(8'h00, 0, 0, 0, 0);
        gap(1);
        frame(8'hFF, 0, 0, 0, 0);
        gap(0);

        // config change and new write in the middle of a frame
        push(8'h81);
        fork
            frame(8'h81, 0, 0, 0, 0);
            begin
                repeat (10) @(posedge clk);
                #2;
                cfg_parity = 2'b10;
                cfg_stop2  = 1'b1;
                TxD_start  = 1'b1;
                TxD_data   = 8'h3C;
                @(posedge clk);
                #2;
                TxD_start = 1'b0;
            end
        join
        gap(1);
        frame(8'h3C, 1, 1, 1, 0);
        gap(0);

        // fill the FIFO, then overflow it
        cfg_parity = 2'b00;
        cfg_stop2  = 1'b0;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        push(8'h55);
        chk("fill_full", fifo_full, 1);
        chk("fill_count", fifo_count, 4);
        chk("fill_ovf", tx_overflow, 0);
        push(8'h66);
        chk("ovf_set", tx_overflow, 1);
        chk("ovf_count", fifo_count, 4);
        chk("ovf_full", fifo_full, 1);
        frame(8'h11, 0, 0, 0, 5);
        gap(1);
        frame(8'h22, 0, 0, 0, 0);
        gap(1);
        frame(8'h33, 0, 0, 0, 0);
        gap(1);
        frame(8'h44, 0, 0, 0, 0);
        gap(1);
        frame(8'h55, 0, 0, 0, 0);
        gap(0);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (TxD == 1'b0) lows++;
        end
        chk("dropped_never_sent", lows, 0);
        chk("ovf_sticky", tx_overflow, 1);

        // reset in the middle of a frame with another word queued
        push(8'h5A);
        TxD_start = 1'b1;
        TxD_data  = 8'hA5;
        tick();
        repeat (14) tick();
        chk("pre_rst_txd", TxD, 0);
        chk("pre_rst_count", fifo_count, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_txd", TxD, 1);
        chk("mid_rst_busy", TxD_busy, 0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_ovf", tx_overflow, 0);
        repeat (2) tick();
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (TxD == 1'b0) lows++;
        end
        chk("post_rst_quiet", lows, 0);
        chk("post_rst_busy", TxD_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter ClkFrequency, default 25000000, input clock frequency in Hz.
REQ-002 Parameter Baud, default 115200, line rate; DIV = ClkFrequency/Baud (integer division) clocks per bit; DIV < 2 shall be a elaboration error.
REQ-003 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-004 Parameter FIFO_DEPTH, default 16, transmit FIFO entries; power of two, at least 2.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 TxD_start  input  1  write strobe; pushes TxD_data into FIFO when not full.
REQ-008 TxD_data  input  DATA_BITS  word to transmit.
REQ-009 cfg_parity  input  2  00 none, 01 even, 10 odd, 11 reserved (treated as none).
REQ-010 cfg_stop2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-011 TxD  output  1  serial line, idle high.
REQ-012 TxD_busy  output  1  high while a frame is in progress or FIFO non-empty.
REQ-013 fifo_full  output  1  FIFO holds FIFO_DEPTH words.
REQ-014 fifo_count  output  log2(FIFO_DEPTH)+1  words currently stored.
REQ-015 tx_overflow  output  1  sticky flag, set when a write is dropped.

Function
REQ-016 FIFO write: TxD_start high at a clock edge with fifo_full low stores TxD_data; fifo_count increments at that edge.
REQ-017 Write with fifo_full high is dropped and sets tx_overflow at that edge, even if a pop occurs the same cycle.
REQ-018 Simultaneous accepted write and pop leaves fifo_count unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-019 FSM states IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE: if FIFO non-empty at an edge, pop head word into shift register, latch cfg_parity and cfg_stop2, clear bit counter, go to START.
REQ-021 Config inputs are sampled only at the pop; changes mid-frame shall not affect the current frame.
REQ-022 Each of START, each data bit, PARITY, and each stop bit lasts exactly DIV clocks; the bit-period counter restarts at every pop.
REQ-023 START drives TxD=0; DATA drives shift register bit 0, LSB first, shifting right after each bit, DATA_BITS bits total.
REQ-024 PARITY entered only when latched mode is 01 or 10; drives XOR of data bits (even) or its inverse (odd); otherwise DATA goes directly to STOP.
REQ-025 STOP drives TxD=1 for 1 or 2 bit periods per latched cfg_stop2, then returns to IDLE.
REQ-026 IDLE drives TxD=1; TxD is registered (glitch-free).
REQ-027 Latency: with FSM idle and FIFO empty, TxD_start at edge k makes TxD go low after edge k+1.
REQ-028 Back-to-back: if FIFO non-empty when STOP ends, the next START begins at the next edge, giving at most one extra idle-high clock between frames.
REQ-029 TxD_busy = (state != IDLE) | (fifo_count != 0).
REQ-030 Frame length in clocks = DIV x (1 + DATA_BITS + parity_en + 1 + cfg_stop2).

Reset
REQ-031 rst high asynchronously forces: state IDLE, TxD=1, TxD_busy=0, fifo_count=0, fifo_full=0, tx_overflow=0, pointers and counters 0.
REQ-032 Reset asserted mid-frame aborts the frame immediately and discards all queued words; no partial frame resumes after release.
REQ-033 First write accepted at the first rising edge after rst deasserts.

Verification (ClkFrequency=16, Baud=4 so DIV=4, DATA_BITS=8, FIFO_DEPTH=4)
REQ-034 Write 8'hA5, parity 00, stop2=0 -> TxD bits 0,1,0,1,0,0,1,0,1,1, each 4 clocks, 40 clocks total; TxD_busy falls after the final stop bit.
REQ-035 Write 8'hA5 with parity 01 then with 10 -> parity bit 0 then 1; with stop2=1 frame is 48 clocks and the stop level lasts 8 clocks.
REQ-036 Five writes in consecutive cycles while idle -> first pops immediately, remaining four fill FIFO, fifo_full=1, no overflow; a sixth write while full sets tx_overflow=1 and its word is never transmitted.
REQ-037 Queue 8'h00, 8'hFF -> two contiguous frames separated by at most one extra idle-high clock, correct LSB-first bits.
REQ-038 Assert rst at clock 15 of a frame -> TxD=1 the same cycle, fifo_count=0, TxD_busy=0; after release no further frame bits appear.
REQ-039 Toggle cfg_parity and cfg_stop2 mid-frame -> current frame unchanged; next frame uses the new values.
